// File: rtl/detranslater_pkg.sv
// Shared constants for the detranslater: FSM states, FIFO entry layout and
// header beat field positions.
package detranslater_pkg;

  localparam logic [1:0] HDR_MARKER = 2'b10;

  typedef enum logic {
    S_HEAD = 1'b0,
    S_BODY = 1'b1
  } state_t;

  // Entry is {selector, selector3, in_1, in_2, in_3}, MSB first.
  function automatic int unsigned entry_width(input int unsigned idw, input int unsigned dw);
    return 2 + 2 * idw + dw;
  endfunction

  function automatic int unsigned ofs_in2(input int unsigned dw);
    return dw;
  endfunction

  function automatic int unsigned ofs_in1(input int unsigned idw, input int unsigned dw);
    return dw + idw;
  endfunction

  function automatic int unsigned ofs_sel3(input int unsigned idw, input int unsigned dw);
    return dw + 2 * idw;
  endfunction

  function automatic int unsigned ofs_sel(input int unsigned idw, input int unsigned dw);
    return dw + 2 * idw + 1;
  endfunction

  localparam int unsigned ENTRY_W = 48;

  localparam int unsigned HDR_MARKER_LSB = 30;
  localparam int unsigned HDR_FLAG_BIT   = 29;
  localparam int unsigned HDR_A_LSB      = 16;
  localparam int unsigned HDR_B_LSB      = 8;

endpackage

// File: rtl/detranslater_fifo.sv
// Synchronous FIFO with asynchronous active-low clear and occupancy count.
module detranslater_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 48
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign rdata = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/detranslater.sv
// Re-serializes buffered translated transactions into optional header beat
// plus data beat on a 32-bit valid/ready stream.
module detranslater
  import detranslater_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IDW   = 7,
  parameter int unsigned DW    = 32
) (
  input  logic           clk,
  input  logic           ENB,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [IDW-1:0] in_1,
  input  logic [IDW-1:0] in_2,
  input  logic [DW-1:0]  in_3,
  input  logic           selector,
  input  logic           selector3,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DW-1:0]  out_data,
  output logic           out_sop,
  output logic           out_eop,
  output logic           fifo_full,
  output logic           fifo_empty,
  output logic [15:0]    pkt_cnt
);

  localparam int unsigned EW = entry_width(IDW, DW);

  state_t                    state;
  logic   [EW-1:0]           head;
  logic   [EW-1:0]           entry;
  logic   [$clog2(DEPTH):0]  count;
  logic                      push;
  logic                      pop;
  logic                      accept;
  logic                      head_sel;
  logic                      head_sel3;
  logic   [IDW-1:0]          head_a;
  logic   [IDW-1:0]          head_b;
  logic   [DW-1:0]           head_payload;
  logic   [DW-1:0]           hdr_beat;
  logic   [DW-1:0]           data_beat;

  assign entry    = {selector, selector3, in_1, in_2, in_3};
  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;

  assign head_sel     = head[ofs_sel(IDW, DW)];
  assign head_sel3    = head[ofs_sel3(IDW, DW)];
  assign head_a       = head[ofs_in1(IDW, DW) +: IDW];
  assign head_b       = head[ofs_in2(DW) +: IDW];
  assign head_payload = head[DW-1:0];

  assign out_valid = !fifo_empty;
  assign accept    = out_valid && out_ready;
  assign pop       = accept && (state == S_BODY || !head_sel);

  detranslater_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (ENB),
    .push  (push),
    .pop   (pop),
    .wdata (entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  always_comb begin
    hdr_beat = '0;
    hdr_beat[HDR_MARKER_LSB +: 2] = HDR_MARKER;
    hdr_beat[HDR_FLAG_BIT]        = head_sel3;
    hdr_beat[HDR_A_LSB +: IDW]    = head_a;
    hdr_beat[HDR_B_LSB +: IDW]    = head_b;
  end

  always_comb begin
    data_beat = head_payload;
    if (head_sel3) begin
      for (int unsigned i = 0; i < DW / 8; i++) begin
        data_beat[8*i +: 8] = head_payload[DW - 8*(i+1) +: 8];
      end
    end
  end

  // Beat fields are zero whenever the FIFO is empty; otherwise they are a pure
  // function of the head entry and state, so they hold under backpressure.
  always_comb begin
    out_data = '0;
    out_sop  = 1'b0;
    out_eop  = 1'b0;
    if (out_valid) begin
      if (state == S_HEAD && head_sel) begin
        out_data = hdr_beat;
        out_sop  = 1'b1;
      end else begin
        out_data = data_beat;
        out_sop  = (state == S_HEAD);
        out_eop  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge ENB) begin
    if (!ENB) begin
      state   <= S_HEAD;
      pkt_cnt <= '0;
    end else begin
      if (accept) begin
        case (state)
          S_HEAD:  if (head_sel) state <= S_BODY;
          S_BODY:  state <= S_HEAD;
          default: state <= S_HEAD;
        endcase
      end
      if (pop) pkt_cnt <= pkt_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_detranslater.sv
// Directed self-checking bench for detranslater.
module tb_detranslater;

  logic        clk = 1'b0;
  logic        ENB;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_1;
  logic [6:0]  in_2;
  logic [31:0] in_3;
  logic        selector;
  logic        selector3;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_sop;
  logic        out_eop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [15:0] pkt_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  detranslater #(.DEPTH(4), .IDW(7), .DW(32)) dut (
    .clk        (clk),
    .ENB        (ENB),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_1       (in_1),
    .in_2       (in_2),
    .in_3       (in_3),
    .selector   (selector),
    .selector3  (selector3),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sop    (out_sop),
    .out_eop    (out_eop),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .pkt_cnt    (pkt_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic s, input logic s3, input logic [6:0] a,
                          input logic [6:0] b, input logic [31:0] d);
    selector = s; selector3 = s3; in_1 = a; in_2 = b; in_3 = d;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    ENB = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    selector = 1'b0; selector3 = 1'b0; in_1 = '0; in_2 = '0; in_3 = '0;
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
    checks++; if ({out_sop, out_eop} !== 2'b00) begin errors++; $display("FAIL rst_sop_eop got=%b exp=00", {out_sop, out_eop}); end
    checks++; if ({fifo_empty, fifo_full, in_ready} !== 3'b101) begin errors++; $display("FAIL rst_flags got=%b exp=101", {fifo_empty, fifo_full, in_ready}); end
    checks++; if (pkt_cnt !== 16'h0) begin errors++; $display("FAIL rst_pkt_cnt got=%h exp=0", pkt_cnt); end
    ENB = 1'b1;
    step();
  endtask

  task automatic test_header();
    out_ready = 1'b1;
    push_one(1'b1, 1'b0, 7'h15, 7'h2A, 32'h12345678);
    checks++; if ({out_valid, out_sop, out_eop} !== 3'b110) begin errors++; $display("FAIL hdr_ctl got=%b exp=110", {out_valid, out_sop, out_eop}); end
    checks++; if (out_data !== 32'h80152A00) begin errors++; $display("FAIL hdr_beat got=%h exp=80152a00", out_data); end
    step();
    checks++; if ({out_valid, out_sop, out_eop} !== 3'b101) begin errors++; $display("FAIL hdr_body_ctl got=%b exp=101", {out_valid, out_sop, out_eop}); end
    checks++; if (out_data !== 32'h12345678) begin errors++; $display("FAIL hdr_body got=%h exp=12345678", out_data); end
    step();
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL hdr_drained got=%b exp=1", fifo_empty); end
    checks++; if (pkt_cnt !== 16'd1) begin errors++; $display("FAIL hdr_pkt_cnt got=%0d exp=1", pkt_cnt); end
  endtask

  task automatic test_data_only();
    out_ready = 1'b1;
    push_one(1'b0, 1'b1, 7'h00, 7'h00, 32'hAABBCCDD);
    checks++; if ({out_valid, out_sop, out_eop} !== 3'b111) begin errors++; $display("FAIL donly_ctl got=%b exp=111", {out_valid, out_sop, out_eop}); end
    checks++; if (out_data !== 32'hDDCCBBAA) begin errors++; $display("FAIL donly_data got=%h exp=ddccbbaa", out_data); end
    step();
    checks++; if (pkt_cnt !== 16'd2) begin errors++; $display("FAIL donly_pkt_cnt got=%0d exp=2", pkt_cnt); end
  endtask

  task automatic test_fill_drain();
    out_ready = 1'b0;
    selector = 1'b0; selector3 = 1'b0; in_1 = '0; in_2 = '0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_3 = 32'h1000_0000 + 32'(i);
      checks++; if (in_ready !== (i < 4)) begin errors++; $display("FAIL fill_in_ready[%0d] got=%b exp=%b", i, in_ready, (i < 4)); end
      step();
    end
    in_valid = 1'b0;
    checks++; if ({fifo_full, in_ready} !== 2'b10) begin errors++; $display("FAIL fill_full got=%b exp=10", {fifo_full, in_ready}); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_data !== 32'h1000_0000 + 32'(i)) begin errors++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, out_data, 32'h1000_0000 + 32'(i)); end
      step();
    end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL drain_empty got=%b exp=1", fifo_empty); end
    checks++; if (pkt_cnt !== 16'd6) begin errors++; $display("FAIL drain_pkt_cnt got=%0d exp=6", pkt_cnt); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    push_one(1'b1, 1'b1, 7'h7F, 7'h01, 32'h01020304);
    checks++; if ({out_data, out_sop, out_eop} !== {32'hA07F0100, 2'b10}) begin errors++; $display("FAIL bp_hdr got=%h/%b exp=a07f0100/10", out_data, {out_sop, out_eop}); end
    step();
    checks++; if ({out_data, out_sop, out_eop} !== {32'hA07F0100, 2'b10}) begin errors++; $display("FAIL bp_hdr_hold got=%h/%b exp=a07f0100/10", out_data, {out_sop, out_eop}); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if ({out_data, out_sop, out_eop} !== {32'h04030201, 2'b01}) begin errors++; $display("FAIL bp_body got=%h/%b exp=04030201/01", out_data, {out_sop, out_eop}); end
    step();
    checks++; if ({out_data, out_sop, out_eop} !== {32'h04030201, 2'b01}) begin errors++; $display("FAIL bp_body_hold got=%h/%b exp=04030201/01", out_data, {out_sop, out_eop}); end
    out_ready = 1'b1;
    step();
    checks++; if ({fifo_empty, pkt_cnt} !== {1'b1, 16'd7}) begin errors++; $display("FAIL bp_done got=%b/%0d exp=1/7", fifo_empty, pkt_cnt); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    push_one(1'b1, 1'b0, 7'h11, 7'h22, 32'hCAFEF00D);
    step();
    checks++; if ({out_data, out_eop} !== {32'hCAFEF00D, 1'b1}) begin errors++; $display("FAIL mid_body got=%h/%b exp=cafef00d/1", out_data, out_eop); end
    ENB = 1'b0;
    #1;
    checks++; if ({out_valid, out_sop, out_eop} !== 3'b000) begin errors++; $display("FAIL mid_rst_ctl got=%b exp=000", {out_valid, out_sop, out_eop}); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL mid_rst_data got=%h exp=0", out_data); end
    checks++; if ({fifo_empty, fifo_full, in_ready, pkt_cnt} !== {3'b101, 16'd0}) begin errors++; $display("FAIL mid_rst_flags got=%b/%0d exp=101/0", {fifo_empty, fifo_full, in_ready}, pkt_cnt); end
    ENB = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_no_replay got=%b exp=0", out_valid); end
    push_one(1'b1, 1'b0, 7'h01, 7'h02, 32'h00000055);
    checks++; if ({out_data, out_sop, out_eop} !== {32'h80010200, 2'b10}) begin errors++; $display("FAIL mid_new_hdr got=%h/%b exp=80010200/10", out_data, {out_sop, out_eop}); end
    step();
    checks++; if (out_data !== 32'h00000055) begin errors++; $display("FAIL mid_new_body got=%h exp=00000055", out_data); end
    step();
    checks++; if (pkt_cnt !== 16'd1) begin errors++; $display("FAIL mid_pkt_cnt got=%0d exp=1", pkt_cnt); end
  endtask

  task automatic drain_wait(input string name);
    int n;
    n = 0;
    while (!fifo_empty && n < 10) begin
      step();
      n++;
    end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL %s_timeout got=%b exp=1", name, fifo_empty); end
  endtask

  task automatic test_wrap();
    ENB = 1'b0;
    #2;
    ENB = 1'b1;
    step();
    out_ready = 1'b1;
    selector = 1'b0; selector3 = 1'b0; in_1 = '0; in_2 = '0; in_3 = 32'h0;
    in_valid = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      step();
    end
    in_valid = 1'b0;
    drain_wait("wrap_pre");
    checks++; if (pkt_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_pre got=%h exp=ffff", pkt_cnt); end
    push_one(1'b0, 1'b0, 7'h0, 7'h0, 32'h1);
    drain_wait("wrap_post");
    checks++; if (pkt_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_post got=%h exp=0000", pkt_cnt); end
  endtask

  initial begin
    test_reset();
    test_header();
    test_data_only();
    test_fill_drain();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/detranslater.md
# detranslater

Reverse-direction block of the QoS translater path. Accepts translated transactions (two 7-bit class/queue fields, one 32-bit payload, per-transaction `selector`/`selector3` controls) on a valid/ready input. Buffers them in a small FIFO. Re-serializes each one onto a 32-bit valid/ready output stream as an optional header beat followed by a data beat, restoring the framing the translater removed.

## Interface
Parameters:
- `DEPTH`, 4, FIFO entries; power of two, ≥ 2
- `IDW`, 7, width of `in_1`/`in_2`
- `DW`, 32, width of `in_3`/`out_data`

Ports:
- `clk` input 1: single clock; all state on rising edge
- `ENB` input 1: asynchronous, active-low reset
- `in_valid` input 1: transaction present on `in_*`
- `in_ready` output 1: block can accept; `!fifo_full`
- `in_1` input IDW: class field A
- `in_2` input IDW: class field B
- `in_3` input DW: payload
- `selector` input 1: 1 = emit header + data, 0 = data only
- `selector3` input 1: 1 = byte-reverse payload, flag in header
- `out_valid` output 1: beat present on `out_data`
- `out_ready` input 1: downstream accepts beat
- `out_data` output DW: header or data beat
- `out_sop` output 1: first beat of transaction
- `out_eop` output 1: last beat of transaction
- `fifo_full` output 1: occupancy == DEPTH
- `fifo_empty` output 1: occupancy == 0
- `pkt_cnt` output 16: transactions fully sent, wraps 0xFFFF→0

## Operation
- Push: `in_valid && in_ready` at a rising edge writes {selector, selector3, in_1, in_2, in_3} (2+2·IDW+DW = 48 bits) to the FIFO tail.
- Pop: the head entry is removed on acceptance of its last beat.
- FSM has two states, S_HEAD and S_BODY.
  - S_HEAD, head has `selector`=1: drive the header beat, `out_sop`=1, `out_eop`=0. On accept, go to S_BODY.
  - S_HEAD, head has `selector`=0: drive the data beat, `out_sop`=`out_eop`=1. On accept, pop and stay in S_HEAD.
  - S_BODY: drive the data beat, `out_sop`=0, `out_eop`=1. On accept, pop and go to S_HEAD.
- Header beat layout:
  - [31:30]=2'b10
  - [29]=selector3
  - [28:23]=0
  - [22:16]=in_1
  - [15]=0
  - [14:8]=in_2
  - [7:0]=0
- Data beat: `in_3` if `selector3`=0, else byte-reversed {in_3[7:0], in_3[15:8], in_3[23:16], in_3[31:24]}.
- `out_valid` = `!fifo_empty`. `out_data`, `out_sop` and `out_eop` are 0 whenever `out_valid`=0.
- `pkt_cnt` increments by 1 on each pop.

## Timing
- Reset (`ENB`=0, asynchronous): FIFO pointers and occupancy cleared, FSM → S_HEAD, `pkt_cnt`=0.
- Output values during reset: `out_valid`=0, `out_data`=0, `out_sop`=0, `out_eop`=0, `fifo_empty`=1, `fifo_full`=0, `in_ready`=1.
- Reset asserted mid-transaction discards all buffered entries, including a half-sent header/data pair. No beat is replayed after release.
- Latency: an entry pushed at edge N gives `out_valid`=1 in cycle N+1 (combinational from occupancy).
- Output hold: while `out_valid && !out_ready`, `out_data`, `out_sop` and `out_eop` stay stable.
- `in_ready` depends only on registered occupancy. There is no combinational path from `out_ready` to `in_ready`.
- Full: when occupancy == DEPTH, `in_ready`=0, even in a cycle where a pop occurs. A push is accepted the cycle after occupancy drops.
- Simultaneous push and pop when not full and not empty: occupancy unchanged, both take effect.
- Empty: a push into an empty FIFO is not visible until the next cycle (no bypass).
- Pointer wrap-around is modulo DEPTH.
- Throughput: 1 beat/cycle with `out_ready` held high; a header transaction occupies 2 cycles.

## Structure
- Package `detranslater_pkg` holds:
  - `HDR_MARKER`=2'b10
  - state encodings S_HEAD/S_BODY
  - entry width constant and field offsets
  - header field positions
- Sub-module `detranslater_fifo`: parameterized synchronous FIFO, async active-low clear, push/pop/full/empty/occupancy. The top holds the FSM, beat formatting and `pkt_cnt`.

## Test plan
- Reset, then one push (`selector`=1, `selector3`=0, in_1=7'h15, in_2=7'h2A, in_3=32'h12345678), `out_ready`=1:
  - beat 1: header 32'h80152A00, `sop`=1
  - beat 2: data 32'h12345678, `eop`=1
  - `pkt_cnt`=1
- Push with `selector`=0, `selector3`=1, in_3=32'hAABBCCDD:
  - single beat 32'hDDCCBBAA, `sop`=`eop`=1
- Fill and drain with `out_ready`=0:
  - push 5 back-to-back; `in_ready` drops after 4 pushes, `fifo_full`=1, 5th not accepted
  - release `out_ready`; 4 transactions emerge in order
- Backpressure: toggle `out_ready` every cycle during a header transaction:
  - `out_data`/`sop`/`eop` held stable on each stalled cycle
  - no beat duplicated or lost
- Assert `ENB`=0 after the header beat is accepted and before the data beat:
  - all outputs return to reset values immediately
  - after release, new pushes emerge starting with S_HEAD
- Preload `pkt_cnt` to 0xFFFF by sending 65535 transactions, then send 1 more:
  - `pkt_cnt` wraps to 0
